clk_ctrl: RTL
=============

CLK_CTRL -- requirements
Module: clk_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 8, width of divide-ratio input.
REQ-002 SHALL have parameter CNT_W, default 16, width of tick counter.
REQ-003 SHALL have port clk_clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_clk  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start_i  input  1  request to start divided-clock generation.
REQ-006 SHALL have port stop_i  input  1  request to stop divided-clock generation.
REQ-007 SHALL have port div_i  input  DIV_W  half-period minus one, in clk_clk cycles.
REQ-008 SHALL have port clk_div_o  output  1  registered divided clock.
REQ-009 SHALL have port tick_o  output  1  one-cycle pulse per divided-clock rising edge.
REQ-010 SHALL have port busy_o  output  1  high while not IDLE.
REQ-011 SHALL have port done_o  output  1  one-cycle pulse on return to IDLE.
REQ-012 SHALL have port tick_cnt_o  output  CNT_W  count of ticks since last start.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, STOP.
REQ-014 IDLE: start_i=1 -> RUN next cycle; div_i captured into div_q; half-period counter cnt=0; clk_div_o=0.
REQ-015 div_i SHALL be sampled only on start acceptance; changes while busy are ignored.
REQ-016 RUN: cnt increments each cycle; at cnt==div_q, cnt->0 and clk_div_o toggles; period = 2*(div_q+1) cycles, 50% duty.
REQ-017 div_q=0 SHALL give clk_div_o = clk_clk/2 (first toggle 1 cycle after entering RUN).
REQ-018 tick_o SHALL be high exactly in the first cycle clk_div_o is 1 after each 0->1 toggle.
REQ-019 RUN: stop_i=1 with clk_div_o=0 -> IDLE next cycle, clk_div_o stays 0 (no toggle that cycle).
REQ-020 RUN: stop_i=1 with clk_div_o=1 -> STOP; counting continues; at cnt==div_q clk_div_o->0 and state->IDLE (high phase never truncated).
REQ-021 start_i and stop_i simultaneous: stop wins in RUN/STOP; start wins in IDLE.
REQ-022 start_i in RUN or STOP and stop_i in IDLE SHALL be ignored.
REQ-023 done_o SHALL pulse one cycle, registered, in the first IDLE cycle after RUN/STOP.
REQ-024 busy_o SHALL equal (state != IDLE), registered.

Reset
REQ-025 rst_clk=1 SHALL immediately force IDLE, cnt=0, div_q=0, clk_div_o=0, tick_o=0, busy_o=0, done_o=0, tick_cnt_o=0.
REQ-026 Reset mid-RUN/STOP SHALL abort without done_o pulse; first start after release behaves per REQ-014.

Configuration
REQ-027 Macro CLK_CTRL_TICK_CNT_EN defined: tick_cnt_o increments on each tick_o, wraps all-ones->0, clears to 0 on start acceptance, holds in IDLE.
REQ-028 Macro undefined: counter not built; tick_cnt_o tied to 0; port list unchanged.

Structure
REQ-029 Package clk_ctrl_pkg SHALL hold the state enum (IDLE, RUN, STOP) and default DIV_W/CNT_W constants.
REQ-030 Sub-module clk_ctrl_div SHALL hold the half-period counter and toggle register (inputs enable, clear, div_q; outputs clk_div, toggle strobe); FSM, tick, done and counter stay in clk_ctrl.

Verification
REQ-031 div_i=0, start pulse -> clk_div_o period 2 cycles, tick_o every 2 cycles, busy_o=1.
REQ-032 div_i=3, start, 40 cycles, stop while clk_div_o=1 -> high phase completes 4 cycles, clk_div_o=0, done_o one pulse, busy_o=0; with macro tick_cnt_o=5.
REQ-033 div_i=3 running, div_i changed to 9 -> period stays 8 cycles until next start.
REQ-034 start_i and stop_i both 1 in RUN -> stop taken; both 1 in IDLE -> RUN entered.
REQ-035 rst_clk asserted mid-RUN between clock edges -> all outputs 0 immediately, no done_o.
REQ-036 With macro, CNT_W=4, div_i=0, 17 ticks -> tick_cnt_o wraps to 1; without macro tick_cnt_o=0 throughout.

Source files
------------

// File: rtl/clk_ctrl_pkg.sv
// rtl/clk_ctrl_pkg.sv - shared types and default widths for the clock divider controller
package clk_ctrl_pkg;

  // Default width of the divide-ratio input (half-period minus one)
  localparam int DIV_W_DEF = 8;

  // Default width of the tick counter
  localparam int CNT_W_DEF = 16;

  // Controller states; encodings fixed so external tools can decode them
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

endpackage

// File: rtl/clk_ctrl_div.sv
// rtl/clk_ctrl_div.sv - half-period counter and divided-clock toggle register
module clk_ctrl_div
  import clk_ctrl_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk_clk,
  input  logic             rst_clk,
  input  logic             enable,
  input  logic             clear,
  input  logic [DIV_W-1:0] div_q,
  output logic             clk_div,
  output logic             toggle
);

  logic [DIV_W-1:0] cnt;

  // The divided clock flips at the edge that ends this cycle whenever this is high
  assign toggle = enable && (cnt == div_q);

  // Count the half period; wrap to zero and flip the output at the terminal count
  always_ff @(posedge clk_clk or posedge rst_clk) begin
    if (rst_clk) begin
      cnt     <= '0;
      clk_div <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      clk_div <= 1'b0;
    end else if (enable) begin
      if (cnt == div_q) begin
        cnt     <= '0;
        clk_div <= ~clk_div;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_ctrl.sv
// rtl/clk_ctrl.sv - divided-clock generator with start/stop FSM; optional tick counter via CLK_CTRL_TICK_CNT_EN
module clk_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_clk,
  input  logic             rst_clk,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             clk_div_o,
  output logic             tick_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] tick_cnt_o
);

  state_e           state;
  state_e           state_nxt;
  logic [DIV_W-1:0] div_q;
  logic             start_acc;
  logic             div_en;
  logic             toggle;
  logic             clk_div;
  logic             rise;

  // A start is only honoured from IDLE; it also clears the divider
  assign start_acc = (state == IDLE) && start_i;

  // Divider runs in RUN unless a stop lands in the low phase, and always in STOP
  // so the high phase is never cut short
  assign div_en = ((state == RUN) && !(stop_i && !clk_div)) || (state == STOP);

  // Rising toggle of the divided clock
  assign rise = toggle && !clk_div;

  clk_ctrl_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk_clk (clk_clk),
    .rst_clk (rst_clk),
    .enable  (div_en),
    .clear   (start_acc),
    .div_q   (div_q),
    .clk_div (clk_div),
    .toggle  (toggle)
  );

  assign clk_div_o = clk_div;

  // Next-state logic; stop beats start once running, start beats stop in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop_i) begin
          if (!clk_div || toggle) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (toggle) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, captured ratio and registered status strobes
  always_ff @(posedge clk_clk or posedge rst_clk) begin
    if (rst_clk) begin
      state  <= IDLE;
      div_q  <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      tick_o <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_o <= (state_nxt != IDLE);
      done_o <= (state != IDLE) && (state_nxt == IDLE);
      tick_o <= rise;
      if (start_acc) begin
        div_q <= div_i;
      end
    end
  end

`ifdef CLK_CTRL_TICK_CNT_EN
  logic [CNT_W-1:0] tick_cnt;

  // Count divided-clock rising edges since the last accepted start; wraps freely
  always_ff @(posedge clk_clk or posedge rst_clk) begin
    if (rst_clk) begin
      tick_cnt <= '0;
    end else if (start_acc) begin
      tick_cnt <= '0;
    end else if (rise) begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick_cnt_o = tick_cnt;
`else
  assign tick_cnt_o = '0;
`endif

endmodule
